// File: rtl/calendar_display_driver_if.sv
// -----------------------------------------------------------------------------
// calendar_display_driver_if
//   Bundles the date inputs and display/status outputs of the calendar display
//   driver.
//   year/month/day : binary date fields from the calendar counter
//   digits         : committed BCD snapshot DD MM YY
//   seg/dp/an      : active-low 7-segment drive (gfedcba), decimal point, anodes
//   bcd_valid      : a snapshot has been committed since reset
//   busy           : conversion FSM is not idle
//   Modports: master drives the date and observes the display (calendar side or
//   bench); slave is the driver itself.
// -----------------------------------------------------------------------------
interface calendar_display_driver_if;
  logic [6:0]  year;
  logic [4:0]  month;
  logic [4:0]  day;
  logic [23:0] digits;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        bcd_valid;
  logic        busy;

  modport master (
    output year, month, day,
    input  digits, seg, dp, an, bcd_valid, busy
  );

  modport slave (
    input  year, month, day,
    output digits, seg, dp, an, bcd_valid, busy
  );
endinterface

// File: rtl/calendar_display_driver.sv
// -----------------------------------------------------------------------------
// calendar_display_driver
//   Converts the binary year/month/day from the calendar counter to BCD with a
//   sequential double-dabble engine (one iteration per clock) and drives a
//   six-digit multiplexed common-anode 7-segment display as DD.MM.YY.
//   The converted date is committed to the display atomically in one cycle.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : synchronous active-low reset
//     bus     : calendar_display_driver_if.slave (date in, display/status out)
//   Parameter:
//     SCAN_DIV : clk cycles each digit stays lit (2 .. 2^20)
// -----------------------------------------------------------------------------
module calendar_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  calendar_display_driver_if.slave  bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble iteration on {bcd[7:0], bin[6:0]}: correct the nibbles,
  // then shift the whole register left by one. Only two BCD nibbles are kept,
  // so any hundreds carry falls off the top; the low nibbles are unaffected.
  function automatic logic [14:0] dabble_step(input logic [14:0] s);
    logic [7:0] b;
    b = {add3(s[14:11]), add3(s[10:7])};
    return {b[6:0], s[6:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM state
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        go_q, go_d;
  logic [1:0]  field_q, field_d;
  logic [2:0]  iter_q, iter_d;
  logic [23:0] digits_q, digits_d;
  logic [2:0]  inv_q, inv_d;          // {day, month, year} invalid at commit
  logic [16:0] last_q, last_d;        // {year, month, day} last committed
  logic        valid_q, valid_d;

  // Datapath registers (no reset needed: always loaded before use)
  logic [14:0] sh_q, sh_d;
  logic [6:0]  snap_year_q, snap_year_d;
  logic [4:0]  snap_month_q, snap_month_d;
  logic [4:0]  snap_day_q, snap_day_d;
  logic [7:0]  day_bcd_q, day_bcd_d;
  logic [7:0]  mon_bcd_q, mon_bcd_d;
  logic [7:0]  yr_bcd_q, yr_bcd_d;

  logic [14:0] dabbled;
  logic        mismatch;

  always_comb begin
    state_d      = state_q;
    go_d         = 1'b0;
    field_d      = field_q;
    iter_d       = iter_q;
    digits_d     = digits_q;
    inv_d        = inv_q;
    last_d       = last_q;
    valid_d      = valid_q;
    sh_d         = sh_q;
    snap_year_d  = snap_year_q;
    snap_month_d = snap_month_q;
    snap_day_d   = snap_day_q;
    day_bcd_d    = day_bcd_q;
    mon_bcd_d    = mon_bcd_q;
    yr_bcd_d     = yr_bcd_q;

    dabbled  = dabble_step(sh_q);
    mismatch = !valid_q || ({bus.year, bus.month, bus.day} != last_q);

    case (state_q)
      S_IDLE: begin
        // A mismatch is first registered in go_q; the snapshot is taken on the
        // following edge, which guarantees one non-busy cycle between commits.
        if (go_q) begin
          snap_year_d  = bus.year;
          snap_month_d = bus.month;
          snap_day_d   = bus.day;
          field_d      = 2'd0;
          iter_d       = 3'd0;
          sh_d         = {8'd0, 2'b00, bus.day};
          state_d      = S_CONV;
        end else begin
          go_d = mismatch;
        end
      end

      S_CONV: begin
        if (iter_q == 3'd6) begin
          iter_d = 3'd0;
          case (field_q)
            2'd0: begin
              day_bcd_d = dabbled[14:7];
              field_d   = 2'd1;
              sh_d      = {8'd0, 2'b00, snap_month_q};
            end
            2'd1: begin
              mon_bcd_d = dabbled[14:7];
              field_d   = 2'd2;
              sh_d      = {8'd0, snap_year_q};
            end
            default: begin
              yr_bcd_d = dabbled[14:7];
              state_d  = S_COMMIT;
            end
          endcase
        end else begin
          iter_d = iter_q + 3'd1;
          sh_d   = dabbled;
        end
      end

      S_COMMIT: begin
        digits_d = {day_bcd_q, mon_bcd_q, yr_bcd_q};
        inv_d    = {(snap_day_q == 5'd0),
                    (snap_month_q == 5'd0) || (snap_month_q > 5'd12),
                    (snap_year_q > 7'd99)};
        last_d   = {snap_year_q, snap_month_q, snap_day_q};
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      field_q  <= 2'd0;
      iter_q   <= 3'd0;
      digits_q <= 24'd0;
      inv_q    <= 3'd0;
      last_q   <= 17'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      field_q  <= field_d;
      iter_q   <= iter_d;
      digits_q <= digits_d;
      inv_q    <= inv_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q         <= sh_d;
    snap_year_q  <= snap_year_d;
    snap_month_q <= snap_month_d;
    snap_day_q   <= snap_day_d;
    day_bcd_q    <= day_bcd_d;
    mon_bcd_q    <= mon_bcd_d;
    yr_bcd_q     <= yr_bcd_d;
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          adv;
  logic [23:0]   dig_sh;
  logic [3:0]    nib;
  logic          fld_inv;

  always_comb begin
    pre_d   = pre_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    an_d    = an_q;
    dp_d    = dp_q;
    dig_sh  = 24'd0;
    nib     = 4'd0;
    fld_inv = 1'b0;

    adv = (pre_q == PRE_LAST);
    if (adv) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    if (adv) begin
      idx_d  = (idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1;
      // Drive outputs for the digit being advanced to.
      dig_sh = digits_q >> {idx_d, 2'b00};
      nib    = dig_sh[3:0];
      case (idx_d[2:1])
        2'd2:    fld_inv = inv_q[2];
        2'd1:    fld_inv = inv_q[1];
        default: fld_inv = inv_q[0];
      endcase
      if (!valid_q) begin
        seg_d = 7'h7F;
        an_d  = 6'h3F;
        dp_d  = 1'b1;
      end else begin
        seg_d = fld_inv ? 7'h3F : seg_code(nib);
        an_d  = ~(6'd1 << idx_d);
        dp_d  = !((idx_d == 3'd4) || (idx_d == 3'd2));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= 3'd0;
      seg_q <= 7'h7F;
      an_q  <= 6'h3F;
      dp_q  <= 1'b1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.digits    = digits_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_calendar_display_driver.sv
module tb_calendar_display_driver;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  calendar_display_driver_if cal_if();

  calendar_display_driver #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (cal_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_date(input logic [6:0] y, input logic [4:0] m, input logic [4:0] d);
    cal_if.year  = y;
    cal_if.month = m;
    cal_if.day   = d;
  endtask

  // Detect edge + 23 edges to commit.
  task automatic apply_and_commit(input logic [6:0] y, input logic [4:0] m, input logic [4:0] d);
    set_date(y, m, d);
    repeat (24) tick();
  endtask

  // Align to a freshly loaded day-tens slot; returns 0 if the scan never got there.
  task automatic sync_scan(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (cal_if.an === 6'h1F && n < 40) begin tick(); n++; end
    n = 0;
    while (cal_if.an !== 6'h1F && n < 40) begin tick(); n++; end
    ok = (cal_if.an === 6'h1F);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_date(7'd1, 5'd1, 5'd1);
    repeat (3) tick();
    checks++;
    if (cal_if.digits !== 24'h0 || cal_if.seg !== 7'h7F || cal_if.dp !== 1'b1 ||
        cal_if.an !== 6'h3F || cal_if.bcd_valid !== 1'b0 || cal_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits=%h seg=%h dp=%b an=%h valid=%b busy=%b, required 000000 7f 1 3f 0 0",
               cal_if.digits, cal_if.seg, cal_if.dp, cal_if.an, cal_if.bcd_valid, cal_if.busy);
    end
  endtask

  task automatic test_first_commit();
    reset_n = 1'b1;
    tick();  // detecting edge
    checks++;
    if (cal_if.busy !== 1'b0) begin
      errors++; $display("FAIL first_busy_e0: got %b required 0", cal_if.busy);
    end
    tick();  // snapshot edge
    checks++;
    if (cal_if.busy !== 1'b1) begin
      errors++; $display("FAIL first_busy_e1: got %b required 1", cal_if.busy);
    end
    repeat (21) tick();  // edge 22
    checks++;
    if (cal_if.digits !== 24'h0 || cal_if.bcd_valid !== 1'b0 || cal_if.busy !== 1'b1 ||
        cal_if.an !== 6'h3F || cal_if.seg !== 7'h7F) begin
      errors++;
      $display("FAIL first_e22: digits=%h valid=%b busy=%b an=%h seg=%h required 000000 0 1 3f 7f",
               cal_if.digits, cal_if.bcd_valid, cal_if.busy, cal_if.an, cal_if.seg);
    end
    tick();  // edge 23
    checks++;
    if (cal_if.digits !== 24'h010101 || cal_if.bcd_valid !== 1'b1 || cal_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL first_commit: digits=%h valid=%b busy=%b required 010101 1 0",
               cal_if.digits, cal_if.bcd_valid, cal_if.busy);
    end
  endtask

  task automatic test_scan_order();
    logic [5:0] exp_an  [6] = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
    logic [6:0] exp_seg [6] = '{7'h30, 7'h79, 7'h79, 7'h24, 7'h10, 7'h10};
    logic       exp_dp  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit ok;
    apply_and_commit(7'd99, 5'd12, 5'd31);
    checks++;
    if (cal_if.digits !== 24'h311299) begin
      errors++; $display("FAIL scan_digits: got %h required 311299", cal_if.digits);
    end
    sync_scan(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL scan_sync: an=%h required 1f", cal_if.an);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cal_if.an !== exp_an[k] || cal_if.seg !== exp_seg[k] || cal_if.dp !== exp_dp[k]) begin
        errors++;
        $display("FAIL scan_slot%0d: an=%h seg=%h dp=%b required %h %h %b",
                 k, cal_if.an, cal_if.seg, cal_if.dp, exp_an[k], exp_seg[k], exp_dp[k]);
      end
      repeat (4) tick();
    end
    checks++;
    if (cal_if.an !== 6'h1F) begin
      errors++; $display("FAIL scan_wrap: an=%h required 1f", cal_if.an);
    end
  endtask

  task automatic test_change_mid_conv();
    set_date(7'd99, 5'd12, 5'd5);
    tick();              // edge 0: detect
    tick();              // edge 1: snapshot
    repeat (10) tick();  // edge 11: CONV cycle 10
    cal_if.day = 5'd6;
    repeat (12) tick();  // edge 23: first commit
    checks++;
    if (cal_if.digits !== 24'h051299 || cal_if.bcd_valid !== 1'b1) begin
      errors++; $display("FAIL mid_first: digits=%h valid=%b required 051299 1", cal_if.digits, cal_if.bcd_valid);
    end
    tick();              // edge 24: idle cycle, mismatch seen
    checks++;
    if (cal_if.busy !== 1'b0) begin
      errors++; $display("FAIL mid_idle_gap: busy=%b required 0", cal_if.busy);
    end
    repeat (22) tick();  // edge 46
    checks++;
    if (cal_if.digits !== 24'h051299 || cal_if.busy !== 1'b1) begin
      errors++; $display("FAIL mid_before2: digits=%h busy=%b required 051299 1", cal_if.digits, cal_if.busy);
    end
    tick();              // edge 47: second commit, 24 edges after the first
    checks++;
    if (cal_if.digits !== 24'h061299 || cal_if.busy !== 1'b0) begin
      errors++; $display("FAIL mid_second: digits=%h busy=%b required 061299 0", cal_if.digits, cal_if.busy);
    end
  endtask

  task automatic test_invalid();
    bit ok;
    apply_and_commit(7'd120, 5'd13, 5'd0);
    checks++;
    if (cal_if.digits !== 24'h001320) begin
      errors++; $display("FAIL inv_digits: got %h required 001320", cal_if.digits);
    end
    sync_scan(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL inv_sync: an=%h required 1f", cal_if.an);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cal_if.seg !== 7'h3F) begin
        errors++; $display("FAIL inv_dash%0d: seg=%h an=%h required seg 3f", k, cal_if.seg, cal_if.an);
      end
      repeat (4) tick();
    end
  endtask

  task automatic test_reset_mid_conv();
    set_date(7'd21, 5'd3, 5'd7);
    tick();              // edge 0
    tick();              // edge 1
    repeat (15) tick();  // CONV cycle 15
    reset_n = 1'b0;
    tick();
    checks++;
    if (cal_if.digits !== 24'h0 || cal_if.seg !== 7'h7F || cal_if.dp !== 1'b1 ||
        cal_if.an !== 6'h3F || cal_if.bcd_valid !== 1'b0 || cal_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: digits=%h seg=%h dp=%b an=%h valid=%b busy=%b required 000000 7f 1 3f 0 0",
               cal_if.digits, cal_if.seg, cal_if.dp, cal_if.an, cal_if.bcd_valid, cal_if.busy);
    end
    tick();
    reset_n = 1'b1;
    tick();              // edge 0 after release
    tick();              // edge 1
    checks++;
    if (cal_if.busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart: busy=%b required 1", cal_if.busy);
    end
    repeat (21) tick();  // edge 22
    checks++;
    if (cal_if.digits !== 24'h0 || cal_if.bcd_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_nocommit: digits=%h valid=%b required 000000 0", cal_if.digits, cal_if.bcd_valid);
    end
    tick();              // edge 23
    checks++;
    if (cal_if.digits !== 24'h070321 || cal_if.bcd_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_commit: digits=%h valid=%b required 070321 1", cal_if.digits, cal_if.bcd_valid);
    end
  endtask

  task automatic test_year_wrap();
    logic [6:0] exp_seg [6] = '{7'h40, 7'h79, 7'h40, 7'h79, 7'h40, 7'h40};
    bit ok;
    apply_and_commit(7'd99, 5'd1, 5'd1);
    checks++;
    if (cal_if.digits !== 24'h010199) begin
      errors++; $display("FAIL wrap_99: digits=%h required 010199", cal_if.digits);
    end
    apply_and_commit(7'd0, 5'd1, 5'd1);
    checks++;
    if (cal_if.digits !== 24'h010100) begin
      errors++; $display("FAIL wrap_00: digits=%h required 010100", cal_if.digits);
    end
    sync_scan(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wrap_sync: an=%h required 1f", cal_if.an);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cal_if.seg !== exp_seg[k]) begin
        errors++; $display("FAIL wrap_seg%0d: seg=%h required %h", k, cal_if.seg, exp_seg[k]);
      end
      repeat (4) tick();
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    set_date(7'd0, 5'd0, 5'd0);
    test_reset();
    test_first_commit();
    test_scan_order();
    test_change_mid_conv();
    test_invalid();
    test_reset_mid_conv();
    test_year_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
